// File: rtl/obi_uart_baud_gen.sv
// Baud-rate timebase for the OBI UART: 16x oversample, 2x-baud and 1x-baud edge pulses from clk_i / divisor.
// Optional fractional divisor (D + F/16) is built when OBI_UART_BAUD_FRAC_EN is defined.
module obi_uart_baud_gen #(
    parameter int unsigned DivWidth       = 16,
    parameter int unsigned OversampleRate = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [DivWidth-1:0] divisor_i,
    input  logic                divisor_valid_i,
    input  logic [3:0]          frac_i,
    output logic                oversample_edge_o,
    output logic                double_rate_edge_o,
    output logic                baud_rate_edge_o,
    output logic                div_zero_o
);

    localparam int unsigned PhaseWidth = $clog2(OversampleRate);
    localparam logic [PhaseWidth-1:0] PhaseLast = PhaseWidth'(OversampleRate - 1);
    localparam logic [PhaseWidth-1:0] PhaseHalf = PhaseWidth'(OversampleRate / 2 - 1);

    logic [DivWidth-1:0]   pre_q, pre_d;
    logic [DivWidth-1:0]   term_c;
    logic [PhaseWidth-1:0] phase_q, phase_d;
    logic                  os_q, os_d;
    logic                  dbl_q, dbl_d;
    logic                  baud_q, baud_d;
    logic                  restart_c;
    logic                  tick_c;

    assign div_zero_o = (divisor_i == '0);
    assign restart_c  = divisor_valid_i | ~enable_i | div_zero_o;

`ifdef OBI_UART_BAUD_FRAC_EN
    // extend_q stretches the current prescaler period by one clk after an accumulator carry
    logic [3:0] frac_acc_q, frac_acc_d;
    logic       extend_q, extend_d;
    logic [4:0] frac_sum_c;

    assign frac_sum_c = 5'(frac_acc_q) + 5'(frac_i);
    assign term_c     = extend_q ? divisor_i : divisor_i - DivWidth'(1);
`else
    logic unused_frac;

    assign unused_frac = ^frac_i;
    assign term_c      = divisor_i - DivWidth'(1);
`endif

    assign tick_c = (pre_q == term_c);

    // Next-state: restart has priority over a terminal-count tick
    always_comb begin
        pre_d   = pre_q + DivWidth'(1);
        phase_d = phase_q;
        os_d    = 1'b0;
        dbl_d   = 1'b0;
        baud_d  = 1'b0;
`ifdef OBI_UART_BAUD_FRAC_EN
        frac_acc_d = frac_acc_q;
        extend_d   = extend_q;
`endif
        if (restart_c) begin
            pre_d   = '0;
            phase_d = '0;
`ifdef OBI_UART_BAUD_FRAC_EN
            frac_acc_d = '0;
            extend_d   = 1'b0;
`endif
        end else if (tick_c) begin
            pre_d   = '0;
            phase_d = phase_q + PhaseWidth'(1);
            os_d    = 1'b1;
            dbl_d   = (phase_q == PhaseHalf) || (phase_q == PhaseLast);
            baud_d  = (phase_q == PhaseLast);
`ifdef OBI_UART_BAUD_FRAC_EN
            frac_acc_d = frac_sum_c[3:0];
            extend_d   = frac_sum_c[4];
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pre_q   <= '0;
            phase_q <= '0;
            os_q    <= 1'b0;
            dbl_q   <= 1'b0;
            baud_q  <= 1'b0;
`ifdef OBI_UART_BAUD_FRAC_EN
            frac_acc_q <= '0;
            extend_q   <= 1'b0;
`endif
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
            os_q    <= os_d;
            dbl_q   <= dbl_d;
            baud_q  <= baud_d;
`ifdef OBI_UART_BAUD_FRAC_EN
            frac_acc_q <= frac_acc_d;
            extend_q   <= extend_d;
`endif
        end
    end

    assign oversample_edge_o  = os_q;
    assign double_rate_edge_o = dbl_q;
    assign baud_rate_edge_o   = baud_q;

endmodule

// File: tb/tb_obi_uart_baud_gen.sv
// Randomized scoreboard bench for obi_uart_baud_gen: edge times predicted from the divisor arithmetic.
module tb_obi_uart_baud_gen;

    localparam int unsigned DivWidth = 16;
    localparam int Osr = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                enable;
    logic                dvalid;
    logic [DivWidth-1:0] divisor;
    logic [3:0]          frac;
    logic                os_edge;
    logic                dbl_edge;
    logic                baud_edge;
    logic                div_zero;

    obi_uart_baud_gen #(
        .DivWidth       (DivWidth),
        .OversampleRate (Osr)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .enable_i           (enable),
        .divisor_i          (divisor),
        .divisor_valid_i    (dvalid),
        .frac_i             (frac),
        .oversample_edge_o  (os_edge),
        .double_rate_edge_o (dbl_edge),
        .baud_rate_edge_o   (baud_edge),
        .div_zero_o         (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        bit os;
        bit dbl;
        bit baud;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    // Monitor: every asserted edge must match the oldest predicted tick
    exp_t e;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("div_zero", int'(div_zero), int'(divisor == '0));
            if (os_edge || dbl_edge || baud_edge) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_edge", int'({os_edge, dbl_edge, baud_edge}), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("edge_cycle", cyc, e.t);
                    check("edge_kind", int'({os_edge, dbl_edge, baud_edge}),
                          int'({e.os, e.dbl, e.baud}));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tick k lands at r + k*D + floor((k-1)*F/16); only ticks visible by end_c survive
    task automatic push_seg(input int r, input int end_c, input int d, input int f);
        int   fe;
        int   t;
        exp_t x;
`ifdef OBI_UART_BAUD_FRAC_EN
        fe = f;
`else
        fe = 0 * f;
`endif
        if (d == 0) return;
        for (int k = 1; k < 100000; k++) begin
            t = r + k * d + ((k - 1) * fe) / 16;
            if (t > end_c) break;
            x.t    = t;
            x.os   = 1'b1;
            x.dbl  = (k % (Osr / 2)) == 0;
            x.baud = (k % Osr) == 0;
            exp_q.push_back(x);
        end
    endtask

    // kind 0: divisor_valid pulse, 1: enable low, 2: reset; held for l cycles
    task automatic do_clear(input int kind, input int l, input int d, input int f);
        divisor = DivWidth'(d);
        frac    = 4'(f);
        case (kind)
            0:       dvalid = 1'b1;
            1:       enable = 1'b0;
            default: rst_n  = 1'b0;
        endcase
        for (int i = 0; i < l; i++) begin
            step();
            if (i == 0) begin
                check("clear_os", int'(os_edge), 0);
                check("clear_dbl", int'(dbl_edge), 0);
                check("clear_baud", int'(baud_edge), 0);
            end
        end
        dvalid = 1'b0;
        enable = 1'b1;
        rst_n  = 1'b1;
        check("missed_edges", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_seg(input int kind, input int l, input int d, input int f, input int len);
        int r;
        do_clear(kind, l, d, f);
        r = cyc;
        push_seg(r, r + len, d, f);
        repeat (len) step();
    endtask

    initial begin
        int kind;
        int l;
        int d;
        rst_n   = 1'b0;
        enable  = 1'b1;
        dvalid  = 1'b0;
        divisor = DivWidth'(4);
        frac    = 4'd0;

        run_seg(2, 3, 4, 0, 140);
        run_seg(0, 1, 1, 0, 50);
        run_seg(0, 1, 0, 0, 1000);
        run_seg(0, 1, 2, 0, 30);
        run_seg(0, 1, 10, 0, 7);
        run_seg(0, 1, 3, 0, 60);
        run_seg(0, 1, 4, 0, 37);
        run_seg(1, 5, 4, 0, 150);
        run_seg(0, 1, 3, 8, 1000);
        run_seg(2, 2, 5, 3, 300);

        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 2));
            l    = (kind == 0) ? 1 : int'($urandom_range(1, 6));
            d    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 40))
                                               : int'($urandom_range(0, 12));
            run_seg(kind, l, d, int'($urandom_range(0, 15)), int'($urandom_range(1, 400)));
        end

        do_clear(0, 1, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
